// File: rtl/banked_memory_rf_if.sv
// Bus bundle for banked_memory_rf: two read ports, one byte-masked write port, clear request and status.
// master = controller/datapath side, slave = the storage array.
interface banked_memory_rf_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  localparam int LANES = DATA_WIDTH / 8;

  logic                  clear;
  logic                  busy;

  logic                  read_enable_a;
  logic [ADDR_WIDTH-1:0] read_address_a;
  logic [DATA_WIDTH-1:0] read_data_a;
  logic                  read_valid_a;

  logic                  read_enable_b;
  logic [ADDR_WIDTH-1:0] read_address_b;
  logic [DATA_WIDTH-1:0] read_data_b;
  logic                  read_valid_b;

  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] write_data;
  logic [LANES-1:0]      write_mask;
  logic                  write_error;

  modport master (
    output clear, read_enable_a, read_address_a, read_enable_b, read_address_b,
           write_enable, write_address, write_data, write_mask,
    input  busy, read_data_a, read_valid_a, read_data_b, read_valid_b, write_error
  );

  modport slave (
    input  clear, read_enable_a, read_address_a, read_enable_b, read_address_b,
           write_enable, write_address, write_data, write_mask,
    output busy, read_data_a, read_valid_a, read_data_b, read_valid_b, write_error
  );
endinterface

// File: rtl/banked_memory_rf.sv
// Dual-read, byte-masked single-write storage array with a one-cell-per-cycle clear engine.
// Reads return one cycle after the request; no backpressure, writes are dropped (write_error) while clearing.
module banked_memory_rf #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CELL_COUNT = 256
) (
  input  logic                i_clock,
  input  logic                i_reset,
  banked_memory_rf_if.slave   io_bus
);
  localparam int                    LANES     = DATA_WIDTH / 8;
  localparam int                    IDX_W     = (CELL_COUNT > 1) ? $clog2(CELL_COUNT) : 1;
  localparam logic [ADDR_WIDTH:0]   CELLS     = (ADDR_WIDTH + 1)'(CELL_COUNT);
  localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(CELL_COUNT - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clear_ptr;
  logic [DATA_WIDTH-1:0] r_mem [CELL_COUNT];
  logic [DATA_WIDTH-1:0] r_read_data_a;
  logic [DATA_WIDTH-1:0] r_read_data_b;
  logic                  r_read_valid_a;
  logic                  r_read_valid_b;
  logic                  r_write_error;
  logic                  r_busy;

  logic                  w_idle;
  logic                  w_read_zero;
  logic                  w_wr_in_range;
  logic                  w_wr_accept;
  logic                  w_wr_drop;
  logic                  w_rd_in_range_a;
  logic                  w_rd_in_range_b;
  logic [DATA_WIDTH-1:0] w_wr_old;
  logic [DATA_WIDTH-1:0] w_wr_merged;
  logic [DATA_WIDTH-1:0] w_rd_data_a;
  logic [DATA_WIDTH-1:0] w_rd_data_b;

  assign w_idle          = (r_state == ST_IDLE);
  // The array reads as zero from the edge a clear is accepted, before the engine has touched any cell.
  assign w_read_zero     = !w_idle || io_bus.clear;
  assign w_wr_in_range   = ({1'b0, io_bus.write_address} < CELLS);
  assign w_rd_in_range_a = ({1'b0, io_bus.read_address_a} < CELLS);
  assign w_rd_in_range_b = ({1'b0, io_bus.read_address_b} < CELLS);
  assign w_wr_accept     = io_bus.write_enable && w_idle && !io_bus.clear && w_wr_in_range && !i_reset;
  assign w_wr_drop       = io_bus.write_enable && !(w_idle && !io_bus.clear && w_wr_in_range);

  assign w_wr_old = r_mem[io_bus.write_address[IDX_W-1:0]];

  always_comb begin
    w_wr_merged = w_wr_old;
    for (int i = 0; i < LANES; i++) begin
      if (io_bus.write_mask[i]) begin
        w_wr_merged[8*i +: 8] = io_bus.write_data[8*i +: 8];
      end
    end
  end

  // Write-first: a read hitting the cell being written sees the merged word.
  assign w_rd_data_a = (w_read_zero || !w_rd_in_range_a) ? '0 :
                       (w_wr_accept && (io_bus.read_address_a == io_bus.write_address)) ? w_wr_merged :
                       r_mem[io_bus.read_address_a[IDX_W-1:0]];
  assign w_rd_data_b = (w_read_zero || !w_rd_in_range_b) ? '0 :
                       (w_wr_accept && (io_bus.read_address_b == io_bus.write_address)) ? w_wr_merged :
                       r_mem[io_bus.read_address_b[IDX_W-1:0]];

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_clear_ptr[IDX_W-1:0]] <= '0;
      end else if (w_wr_accept) begin
        r_mem[io_bus.write_address[IDX_W-1:0]] <= w_wr_merged;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= ST_CLEAR;
      r_clear_ptr    <= '0;
      r_read_data_a  <= '0;
      r_read_data_b  <= '0;
      r_read_valid_a <= 1'b0;
      r_read_valid_b <= 1'b0;
      r_write_error  <= 1'b0;
      r_busy         <= 1'b1;
    end else begin
      r_write_error  <= w_wr_drop;
      r_read_valid_a <= io_bus.read_enable_a;
      r_read_valid_b <= io_bus.read_enable_b;
      if (io_bus.read_enable_a) r_read_data_a <= w_rd_data_a;
      if (io_bus.read_enable_b) r_read_data_b <= w_rd_data_b;
      case (r_state)
        ST_IDLE: begin
          if (io_bus.clear) begin
            r_state     <= ST_CLEAR;
            r_clear_ptr <= '0;
            r_busy      <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (r_clear_ptr == LAST_CELL) begin
            r_state     <= ST_IDLE;
            r_clear_ptr <= '0;
            r_busy      <= 1'b0;
          end else begin
            r_clear_ptr <= r_clear_ptr + ADDR_WIDTH'(1);
          end
        end
      endcase
    end
  end

  assign io_bus.busy         = r_busy;
  assign io_bus.read_data_a  = r_read_data_a;
  assign io_bus.read_valid_a = r_read_valid_a;
  assign io_bus.read_data_b  = r_read_data_b;
  assign io_bus.read_valid_b = r_read_valid_b;
  assign io_bus.write_error  = r_write_error;
endmodule

// File: tb/tb_banked_memory_rf.sv
// Bench for banked_memory_rf (16-bit words, 200 cells): directed vectors, clear/reset sequences, random ops.
module tb_banked_memory_rf;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int CC = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  banked_memory_rf_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  banked_memory_rf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CELL_COUNT(CC)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .io_bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: logical array contents plus cycles of clearing still to go.
  logic [DW-1:0] m_mem [256];
  int            m_rem;
  logic [DW-1:0] m_da, m_db;
  logic          m_va, m_vb, m_err;

  typedef struct {
    logic          re_a;
    logic [AW-1:0] ra;
    logic          re_b;
    logic [AW-1:0] rb;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [1:0]    wm;
    logic          e_err;
    logic          e_va;
    logic [DW-1:0] e_da;
    logic          e_vb;
    logic [DW-1:0] e_db;
  } vec_t;

  vec_t tv [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] addr, input bit zero);
    return (zero || int'(addr) >= CC) ? '0 : m_mem[addr];
  endfunction

  task automatic model_edge();
    bit idle, zero;
    if (rst) begin
      m_rem = CC;
      foreach (m_mem[i]) m_mem[i] = '0;
      m_da = '0; m_db = '0; m_va = 1'b0; m_vb = 1'b0; m_err = 1'b0;
      return;
    end
    idle  = (m_rem == 0);
    zero  = !idle || bus.clear;
    m_err = bus.write_enable && (!idle || bus.clear || int'(bus.write_address) >= CC);
    if (bus.write_enable && !m_err) begin
      for (int l = 0; l < DW / 8; l++)
        if (bus.write_mask[l]) m_mem[bus.write_address][8*l +: 8] = bus.write_data[8*l +: 8];
    end
    m_va = bus.read_enable_a;
    m_vb = bus.read_enable_b;
    if (bus.read_enable_a) m_da = model_read(bus.read_address_a, zero);
    if (bus.read_enable_b) m_db = model_read(bus.read_address_b, zero);
    if (idle && bus.clear) begin
      m_rem = CC;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else if (!idle) begin
      m_rem--;
    end
  endtask

  task automatic cyc(input bit chk);
    model_edge();
    @(posedge clk);
    #1;
    if (chk) begin
      check("busy", bus.busy, (m_rem > 0));
      check("write_error", bus.write_error, m_err);
      check("read_valid_a", bus.read_valid_a, m_va);
      check("read_valid_b", bus.read_valid_b, m_vb);
      check("read_data_a", bus.read_data_a, m_da);
      check("read_data_b", bus.read_data_b, m_db);
    end
  endtask

  task automatic drive_idle();
    bus.clear = 1'b0;
    bus.read_enable_a = 1'b0; bus.read_address_a = '0;
    bus.read_enable_b = 1'b0; bus.read_address_b = '0;
    bus.write_enable = 1'b0; bus.write_address = '0; bus.write_data = '0; bus.write_mask = '0;
  endtask

  task automatic wait_clear_done(input string name);
    int n = 0;
    while (bus.busy && n < 1000) begin
      cyc(1);
      n++;
    end
    check(name, n, CC);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 2))
      0:       return AW'($urandom_range(0, 7));
      1:       return AW'($urandom_range(195, 205));
      default: return AW'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 500000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{0, 8'h00, 0, 8'h00, 1, 8'h10, 16'hABCD, 2'b11, 0, 0, 16'h0000, 0, 16'h0000};
    tv[1]  = '{0, 8'h00, 0, 8'h00, 1, 8'h10, 16'h1234, 2'b01, 0, 0, 16'h0000, 0, 16'h0000};
    tv[2]  = '{1, 8'h10, 0, 8'h00, 0, 8'h00, 16'h0000, 2'b00, 0, 1, 16'hAB34, 0, 16'h0000};
    tv[3]  = '{1, 8'h20, 1, 8'h20, 1, 8'h20, 16'h005A, 2'b11, 0, 1, 16'h005A, 1, 16'h005A};
    tv[4]  = '{0, 8'h00, 0, 8'h00, 1, 8'hC8, 16'hFFFF, 2'b11, 1, 0, 16'h0000, 0, 16'h0000};
    tv[5]  = '{1, 8'hC8, 0, 8'h00, 0, 8'h00, 16'h0000, 2'b00, 0, 1, 16'h0000, 0, 16'h0000};
    tv[6]  = '{0, 8'h00, 0, 8'h00, 1, 8'hC7, 16'hBEEF, 2'b11, 0, 0, 16'h0000, 0, 16'h0000};
    tv[7]  = '{1, 8'hC7, 1, 8'hC7, 0, 8'h00, 16'h0000, 2'b00, 0, 1, 16'hBEEF, 1, 16'hBEEF};
    tv[8]  = '{0, 8'h00, 0, 8'h00, 1, 8'hC7, 16'h1111, 2'b00, 0, 0, 16'h0000, 0, 16'h0000};
    tv[9]  = '{0, 8'h00, 1, 8'hC7, 0, 8'h00, 16'h0000, 2'b00, 0, 0, 16'h0000, 1, 16'hBEEF};
    tv[10] = '{1, 8'h30, 0, 8'h00, 1, 8'h30, 16'hCAFE, 2'b10, 0, 1, 16'hCA00, 0, 16'h0000};
    tv[11] = '{0, 8'h00, 1, 8'hFF, 0, 8'h00, 16'h0000, 2'b00, 0, 0, 16'h0000, 1, 16'h0000};

    drive_idle();
    rst = 1'b1;
    cyc(1);
    cyc(1);
    rst = 1'b0;
    bus.read_enable_a = 1'b1;
    bus.read_address_a = 8'h05;
    wait_clear_done("reset_clear_length");

    bus.read_address_a = 8'h00;
    bus.read_enable_b = 1'b1; bus.read_address_b = 8'hFF;
    cyc(1);
    check("post_reset_read_00", {bus.read_valid_a, bus.read_data_a}, {1'b1, 16'h0000});
    check("post_reset_read_ff", {bus.read_valid_b, bus.read_data_b}, {1'b1, 16'h0000});
    drive_idle();
    cyc(1);

    for (int i = 0; i < 12; i++) begin
      bus.read_enable_a = tv[i].re_a; bus.read_address_a = tv[i].ra;
      bus.read_enable_b = tv[i].re_b; bus.read_address_b = tv[i].rb;
      bus.write_enable = tv[i].we; bus.write_address = tv[i].wa;
      bus.write_data = tv[i].wd; bus.write_mask = tv[i].wm;
      cyc(1);
      check($sformatf("vec%0d_err", i), bus.write_error, tv[i].e_err);
      check($sformatf("vec%0d_va", i), bus.read_valid_a, tv[i].e_va);
      check($sformatf("vec%0d_vb", i), bus.read_valid_b, tv[i].e_vb);
      if (tv[i].e_va) check($sformatf("vec%0d_da", i), bus.read_data_a, tv[i].e_da);
      if (tv[i].e_vb) check($sformatf("vec%0d_db", i), bus.read_data_b, tv[i].e_db);
    end
    drive_idle();

    for (int a = 1; a <= 4; a++) begin
      bus.write_enable = 1'b1; bus.write_address = AW'(a); bus.write_data = 16'h7777; bus.write_mask = 2'b11;
      cyc(1);
    end
    bus.clear = 1'b1;
    bus.write_address = 8'h02; bus.write_data = 16'h5555;
    cyc(1);
    check("clear_collide_err", bus.write_error, 1'b1);
    check("clear_start_busy", bus.busy, 1'b1);
    bus.clear = 1'b0;
    bus.write_address = 8'h03; bus.write_data = 16'h1234;
    cyc(1);
    check("busy_write_err", bus.write_error, 1'b1);
    drive_idle();
    begin
      int n = 1;
      while (bus.busy && n < 1000) begin
        cyc(1);
        n++;
      end
      check("clear_length", n, CC);
    end
    for (int a = 1; a <= 4; a++) begin
      bus.read_enable_a = 1'b1; bus.read_address_a = AW'(a);
      bus.read_enable_b = 1'b1; bus.read_address_b = AW'(a);
      cyc(1);
      check($sformatf("cleared_a_%0d", a), {bus.read_valid_a, bus.read_data_a}, {1'b1, 16'h0000});
    end
    drive_idle();

    bus.write_enable = 1'b1; bus.write_address = 8'h50; bus.write_data = 16'h9999; bus.write_mask = 2'b11;
    cyc(1);
    drive_idle();
    bus.clear = 1'b1;
    cyc(1);
    bus.clear = 1'b0;
    for (int k = 0; k < 100; k++) cyc(1);
    rst = 1'b1;
    cyc(1);
    check("mid_clear_reset_busy", bus.busy, 1'b1);
    rst = 1'b0;
    wait_clear_done("mid_clear_reset_length");
    bus.read_enable_a = 1'b1; bus.read_address_a = 8'h50;
    cyc(1);
    check("mid_clear_reset_cell", bus.read_data_a, 16'h0000);

    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 599) == 0);
      bus.clear = ($urandom_range(0, 299) == 0);
      bus.read_enable_a = 1'($urandom_range(0, 1)); bus.read_address_a = rand_addr();
      bus.read_enable_b = 1'($urandom_range(0, 1)); bus.read_address_b = rand_addr();
      bus.write_enable = ($urandom_range(0, 9) < 6); bus.write_address = rand_addr();
      bus.write_data = DW'($urandom); bus.write_mask = 2'($urandom_range(0, 3));
      cyc(1);
    end
    rst = 1'b0;
    drive_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
